dcache_ctrl_wt: RTL and testbench

- Parametrised direct-mapped, write-through, no-write-allocate data cache controller. It is the successor to the fixed 32-line / 3-bit-tag controller.
- Sits between the pipeline MEM stage (MemRead/MemWrite, index, tag) and the main-memory handshake (MsRead/MsWrite/MsReady).
- Owns the tag and valid store. Drives stall to the pipeline, and fill/update to the cache data array.
- New over the previous generation: generic geometry, explicit memory write strobe, latched miss address, bulk invalidate sweep, and saturating hit/miss counters.

---
 rtl/dcache_pkg.sv | 14 +
 rtl/dcache_tag_store.sv | 44 ++++
 rtl/dcache_ctrl_wt.sv | 145 ++++++++++++++
 tb/tb_dcache_ctrl_wt.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// Shared types and default geometry for the write-through data cache controller.
package dcache_pkg;

    typedef enum logic [1:0] {IDLE, RD_MISS, WR_THRU, FLUSH} state_t;

    localparam int DEF_INDEX_W = 5;
    localparam int DEF_TAG_W   = 3;
    localparam int DEF_CNT_W   = 16;

    function automatic int num_lines(input int index_w);
        return 1 << index_w;
    endfunction

endpackage

// File: rtl/dcache_tag_store.sv
// Tag and valid store: combinational hit lookup, one fill port, one sweep-clear port.
module dcache_tag_store
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INDEX_W-1:0] rd_index,
    input  logic [TAG_W-1:0]   rd_tag,
    output logic               hit,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic               clr_en,
    input  logic [INDEX_W-1:0] clr_index
);

    localparam int LINES = num_lines(INDEX_W);

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags [LINES];

    assign hit = valid[rd_index] && (tags[rd_index] == rd_tag);

    // Tags need no reset: a line is only trusted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else begin
            if (wr_en)
                valid[wr_index] <= 1'b1;
            if (clr_en)
                valid[clr_index] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            tags[wr_index] <= wr_tag;
    end

endmodule

// File: rtl/dcache_ctrl_wt.sv
// Direct-mapped write-through, no-write-allocate data cache controller with
// bulk invalidate sweep and saturating hit/miss counters.
module dcache_ctrl_wt
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [INDEX_W-1:0] index,
    input  logic [TAG_W-1:0]   tag,
    input  logic               inv_all,
    input  logic               MsReady,
    output logic               stall,
    output logic               fill,
    output logic               update,
    output logic [INDEX_W-1:0] fill_index,
    output logic               MsRead,
    output logic               MsWrite,
    output logic [CNT_W-1:0]   hit_count,
    output logic [CNT_W-1:0]   miss_count
);

    localparam int LINES = num_lines(INDEX_W);

    state_t             state, state_nxt;
    logic [INDEX_W-1:0] lat_index;
    logic [TAG_W-1:0]   lat_tag;
    logic [INDEX_W-1:0] sweep;
    logic               pend_inv;
    logic               hit;
    logic               latch_en, wr_en, clr_en, hit_inc, miss_inc;

    dcache_tag_store #(.INDEX_W(INDEX_W), .TAG_W(TAG_W)) u_tags (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (index),
        .rd_tag    (tag),
        .hit       (hit),
        .wr_en     (wr_en),
        .wr_index  (lat_index),
        .wr_tag    (lat_tag),
        .clr_en    (clr_en),
        .clr_index (sweep)
    );

    assign fill_index = lat_index;

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        fill      = 1'b0;
        update    = 1'b0;
        MsRead    = 1'b0;
        MsWrite   = 1'b0;
        latch_en  = 1'b0;
        wr_en     = 1'b0;
        clr_en    = 1'b0;
        hit_inc   = 1'b0;
        miss_inc  = 1'b0;
        case (state)
            IDLE: begin
                // A flush request wins; any same-cycle access is held and retried.
                if (inv_all || pend_inv) begin
                    state_nxt = FLUSH;
                    stall     = MemRead | MemWrite;
                end else if (MemRead) begin
                    if (hit) begin
                        hit_inc = 1'b1;
                    end else begin
                        stall     = 1'b1;
                        latch_en  = 1'b1;
                        miss_inc  = 1'b1;
                        state_nxt = RD_MISS;
                    end
                end else if (MemWrite) begin
                    update    = hit;
                    stall     = 1'b1;
                    latch_en  = 1'b1;
                    state_nxt = WR_THRU;
                end
            end
            RD_MISS: begin
                MsRead = 1'b1;
                if (MsReady) begin
                    fill      = 1'b1;
                    wr_en     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    stall = 1'b1;
                end
            end
            WR_THRU: begin
                MsWrite = 1'b1;
                if (MsReady)
                    state_nxt = IDLE;
                else
                    stall = 1'b1;
            end
            FLUSH: begin
                stall  = 1'b1;
                clr_en = 1'b1;
                if (sweep == INDEX_W'(LINES - 1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pend_inv   <= 1'b0;
            sweep      <= '0;
            lat_index  <= '0;
            lat_tag    <= '0;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            state <= state_nxt;
            // IDLE always consumes a pending invalidate by moving to FLUSH.
            if (state == IDLE)
                pend_inv <= 1'b0;
            else if ((state == RD_MISS || state == WR_THRU) && inv_all)
                pend_inv <= 1'b1;
            if (state == FLUSH)
                sweep <= sweep + INDEX_W'(1);
            else
                sweep <= '0;
            if (latch_en) begin
                lat_index <= index;
                lat_tag   <= tag;
            end
            if (hit_inc && hit_count != {CNT_W{1'b1}})
                hit_count <= hit_count + CNT_W'(1);
            if (miss_inc && miss_count != {CNT_W{1'b1}})
                miss_count <= miss_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_dcache_ctrl_wt.sv
// Self-checking bench: directed test-plan scenarios plus random traffic on a
// default-geometry instance (a) and a 4-line / 2-bit-counter instance (b).
module tb_dcache_ctrl_wt;
    import dcache_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       mr = 0, mw = 0, inv = 0, rdy = 0;
    logic [4:0] idx = '0;
    logic [5:0] tg = '0;
    int         cur = 0;

    logic       stall_a, fill_a, update_a, msrd_a, mswr_a;
    logic [4:0] fidx_a;
    logic [15:0] hc_a, mc_a;
    logic       stall_b, fill_b, update_b, msrd_b, mswr_b;
    logic [1:0] fidx_b, hc_b, mc_b;

    logic sel_a, sel_b;
    assign sel_a = (cur == 0);
    assign sel_b = (cur == 1);

    dcache_ctrl_wt u_a (
        .clk(clk), .rst(rst),
        .MemRead(mr & sel_a), .MemWrite(mw & sel_a), .index(idx), .tag(tg[2:0]),
        .inv_all(inv & sel_a), .MsReady(rdy & sel_a),
        .stall(stall_a), .fill(fill_a), .update(update_a), .fill_index(fidx_a),
        .MsRead(msrd_a), .MsWrite(mswr_a), .hit_count(hc_a), .miss_count(mc_a)
    );

    dcache_ctrl_wt #(.INDEX_W(2), .TAG_W(6), .CNT_W(2)) u_b (
        .clk(clk), .rst(rst),
        .MemRead(mr & sel_b), .MemWrite(mw & sel_b), .index(idx[1:0]), .tag(tg),
        .inv_all(inv & sel_b), .MsReady(rdy & sel_b),
        .stall(stall_b), .fill(fill_b), .update(update_b), .fill_index(fidx_b),
        .MsRead(msrd_b), .MsWrite(mswr_b), .hit_count(hc_b), .miss_count(mc_b)
    );

    logic        stall, fill, update, msrd, mswr;
    logic [4:0]  fidx;
    logic [15:0] hc, mc;
    assign stall  = sel_b ? stall_b  : stall_a;
    assign fill   = sel_b ? fill_b   : fill_a;
    assign update = sel_b ? update_b : update_a;
    assign msrd   = sel_b ? msrd_b   : msrd_a;
    assign mswr   = sel_b ? mswr_b   : mswr_a;
    assign fidx   = sel_b ? {3'b0, fidx_b} : fidx_a;
    assign hc     = sel_b ? {14'b0, hc_b}  : hc_a;
    assign mc     = sel_b ? {14'b0, mc_b}  : mc_a;

    // Reference model: which lines hold which tag, and the two counters.
    bit         m_valid [2][32];
    logic [5:0] m_tag   [2][32];
    int         m_hit   [2];
    int         m_miss  [2];
    int         lines   [2] = '{32, 4};
    int         cmax    [2] = '{65535, 3};

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, cur, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 32; i++) m_valid[k][i] = 0;
            m_hit[k]  = 0;
            m_miss[k] = 0;
        end
    endtask

    task automatic chk_cnt();
        chk("hit_count", hc, m_hit[cur]);
        chk("miss_count", mc, m_miss[cur]);
    endtask

    // Runs N flush cycles starting in the first FLUSH cycle; req keeps an access pending.
    task automatic flush_body(input bit req);
        for (int k = 0; k < lines[cur]; k++) begin
            inv = (k == 1);
            mr  = req;
            #1;
            chk("flush_stall", stall, 1);
            chk("flush_msrd", msrd, 0);
            chk("flush_update", update, 0);
            step();
        end
        inv = 0;
        mr  = 0;
        #1;
        chk("flush_end_stall", stall, 0);
        for (int i = 0; i < 32; i++) m_valid[cur][i] = 0;
    endtask

    task automatic do_read(input int i, input int t, input int lat, input bit both, input bit inv_mid);
        bit h;
        mr = 1; mw = both; idx = 5'(i); tg = 6'(t); inv = 0; rdy = 1'($urandom);
        #1;
        h = m_valid[cur][i] && (m_tag[cur][i] == 6'(t));
        chk("rd_update", update, 0);
        chk("rd_mswr", mswr, 0);
        if (h) begin
            chk("rd_hit_stall", stall, 0);
            chk("rd_hit_msrd", msrd, 0);
            if (m_hit[cur] < cmax[cur]) m_hit[cur]++;
            step();
        end else begin
            chk("rd_miss_stall", stall, 1);
            chk("rd_miss_msrd", msrd, 0);
            if (m_miss[cur] < cmax[cur]) m_miss[cur]++;
            step();
            rdy = 0;
            for (int k = 0; k < lat; k++) begin
                inv = inv_mid && (k == 0);
                #1;
                chk("rdm_stall", stall, 1);
                chk("rdm_msrd", msrd, 1);
                chk("rdm_fill", fill, 0);
                step();
            end
            inv = inv_mid && (lat == 0);
            rdy = 1;
            #1;
            chk("fill", fill, 1);
            chk("fill_stall", stall, 0);
            chk("fill_msrd", msrd, 1);
            chk("fill_mswr", mswr, 0);
            chk("fill_index", fidx, i);
            step();
            m_valid[cur][i] = 1;
            m_tag[cur][i]   = 6'(t);
        end
        mr = 0; mw = 0; rdy = 0; inv = 0;
        #1;
        chk_cnt();
        if (inv_mid && !h) begin
            chk("pend_idle_stall", stall, 0);
            step();
            flush_body(0);
        end
    endtask

    task automatic do_write(input int i, input int t, input int lat);
        bit h;
        mr = 0; mw = 1; idx = 5'(i); tg = 6'(t); inv = 0; rdy = 0;
        #1;
        h = m_valid[cur][i] && (m_tag[cur][i] == 6'(t));
        chk("wr_update", update, h);
        chk("wr_stall", stall, 1);
        chk("wr_mswr", mswr, 0);
        step();
        for (int k = 0; k < lat; k++) begin
            #1;
            chk("wrt_stall", stall, 1);
            chk("wrt_mswr", mswr, 1);
            chk("wrt_update", update, 0);
            chk("wrt_msrd", msrd, 0);
            step();
        end
        rdy = 1;
        #1;
        chk("wr_done_stall", stall, 0);
        chk("wr_done_mswr", mswr, 1);
        step();
        rdy = 0; mw = 0;
    endtask

    task automatic do_inv(input bit req);
        inv = 1; mr = req; mw = 0; idx = 5'($urandom_range(0, lines[cur] - 1)); tg = 6'($urandom_range(0, 3));
        #1;
        chk("inv_stall", stall, req);
        step();
        inv = 0;
        flush_body(req);
        #1;
        chk_cnt();
    endtask

    task automatic rand_traffic(input int n);
        for (int r = 0; r < n; r++) begin
            int op, i, t, lat;
            op  = $urandom_range(0, 19);
            i   = $urandom_range(0, (cur == 0) ? 7 : 3);
            t   = $urandom_range(0, 3);
            lat = $urandom_range(0, 3);
            if (op < 12)      do_read(i, t, lat, op == 11, op == 10);
            else if (op < 19) do_write(i, t, lat);
            else              do_inv(1'($urandom));
        end
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_stall"}, stall, 0);
        chk({name, "_fill"}, fill, 0);
        chk({name, "_update"}, update, 0);
        chk({name, "_msrd"}, msrd, 0);
        chk({name, "_mswr"}, mswr, 0);
        chk({name, "_fidx"}, fidx, 0);
        chk({name, "_hc"}, hc, 0);
        chk({name, "_mc"}, mc, 0);
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        cur = 0; #1 chk_all_zero("rst_a");
        cur = 1; #1 chk_all_zero("rst_b");
        cur = 0;
        step();

        // Directed scenarios on the default geometry.
        do_read(5, 3, 3, 0, 0);
        chk("cold_miss_count", mc, 1);
        do_read(5, 3, 0, 0, 0);
        chk("rehit_count", hc, 1);
        do_write(5, 3, 2);
        do_read(5, 3, 0, 0, 0);
        do_write(7, 2, 1);
        do_read(7, 2, 1, 0, 0);
        do_read(2, 1, 0, 0, 0);
        do_read(2, 4, 2, 0, 0);
        do_read(2, 1, 0, 0, 0);

        // Reset while a read miss is outstanding.
        mr = 1; idx = 5'd3; tg = 6'd6; rdy = 0;
        step();
        rst = 1;
        step();
        rst = 0; mr = 0;
        #1;
        chk_all_zero("rst_mid");
        model_reset();
        do_read(2, 4, 0, 0, 0);
        chk("post_rst_miss", mc, 1);

        rand_traffic(60);

        // Four-line instance: full flush, all-miss afterwards, saturation.
        cur = 1;
        step();
        for (int i = 0; i < 4; i++) do_read(i, 40 + i, 1, 0, 0);
        for (int i = 0; i < 4; i++) do_read(i, 40 + i, 0, 0, 0);
        do_inv(0);
        for (int i = 0; i < 4; i++) do_read(i, 40 + i, 0, 0, 0);
        chk("miss_sat", mc, 3);
        do_read(1, 50, 2, 0, 1);
        do_read(1, 50, 0, 0, 0);
        rand_traffic(40);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
